// File: rtl/rx_comando_pkg.sv
// Shared types and constants for the cube-move command receiver.
package rx_comando_pkg;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_R = 3'd1,
        FACE_F = 3'd2,
        FACE_D = 3'd3,
        FACE_L = 3'd4,
        FACE_B = 3'd5
    } face_t;

    typedef enum logic [1:0] {
        MOD_HORARIO      = 2'd0,
        MOD_ANTI_HORARIO = 2'd1,
        MOD_DUPLO        = 2'd2
    } mod_t;

    typedef struct packed {
        face_t face;
        mod_t  mod;
    } movimento_t;

    typedef enum logic [1:0] {
        ESPERA_FACE = 2'd0,
        ESPERA_MOD  = 2'd1
    } estado_t;

    localparam logic [7:0] ASC_U    = 8'h55;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_F    = 8'h46;
    localparam logic [7:0] ASC_D    = 8'h44;
    localparam logic [7:0] ASC_L    = 8'h4C;
    localparam logic [7:0] ASC_B    = 8'h42;
    localparam logic [7:0] ASC_APOS = 8'h27;
    localparam logic [7:0] ASC_DOIS = 8'h32;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_PV   = 8'h3B;
    localparam logic [7:0] ASC_ESP  = 8'h20;
    localparam logic [7:0] ASC_CR   = 8'h0D;

    // True for the six uppercase face letters.
    function automatic logic eh_face(input logic [7:0] c);
        return (c == ASC_U) || (c == ASC_R) || (c == ASC_F) ||
               (c == ASC_D) || (c == ASC_L) || (c == ASC_B);
    endfunction

    // Maps a face letter to its code; callers check eh_face first.
    function automatic face_t face_de(input logic [7:0] c);
        face_t f;
        case (c)
            ASC_R:   f = FACE_R;
            ASC_F:   f = FACE_F;
            ASC_D:   f = FACE_D;
            ASC_L:   f = FACE_L;
            ASC_B:   f = FACE_B;
            default: f = FACE_U;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rx_comando_movimentos_fifo.sv
// First-word fall-through FIFO; full/empty are derived from the occupancy count.
module fifo_sincrona #(
    parameter int WIDTH   = 5,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic [COUNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             vazia;
    logic             cheia;
    logic             pop_ok;
    logic             push_ok;

    assign vazia   = (count == '0);
    assign cheia   = (count == COUNT_W'(DEPTH));
    assign pop_ok  = pop && !vazia && !flush;
    assign push_ok = push && !flush && (!cheia || pop_ok);
    assign dout    = vazia ? '0 : mem[rd_ptr];

    // Storage array is written only on an accepted push and needs no reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping, flush taking priority over traffic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + COUNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - COUNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_comando_movimentos.sv
// Parses ASCII cube-move notation from the UART byte stream and queues 5-bit move codes.
module rx_comando_movimentos
    import rx_comando_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CONT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pronto,
    input  logic [7:0]        dados_ascii,
    input  logic              limpa,
    input  logic              movimento_aceito,
    output logic [4:0]        movimento,
    output logic              movimento_valido,
    output logic [CONT_W-1:0] contagem,
    output logic              sequencia_pronta,
    output logic              erro_char,
    output logic              estouro,
    output logic [1:0]        db_estado
);

    estado_t    estado, estado_prox;
    face_t      pendente, pendente_prox;
    logic       commit;
    mod_t       commit_mod;
    movimento_t commit_dado;
    logic       terminador;
    logic       erro_novo;
    logic       byte_ok;
    logic       cheia;

    assign byte_ok     = pronto && !limpa;
    assign cheia       = (contagem == CONT_W'(DEPTH));
    assign commit_dado = '{face: pendente, mod: commit_mod};
    assign db_estado   = estado;
    assign movimento_valido = (contagem != '0);

    // Parser decisions for the byte sampled this cycle; spaces and CR never change anything.
    always_comb begin
        estado_prox   = estado;
        pendente_prox = pendente;
        commit        = 1'b0;
        commit_mod    = MOD_HORARIO;
        terminador    = 1'b0;
        erro_novo     = 1'b0;
        if (byte_ok && dados_ascii != ASC_ESP && dados_ascii != ASC_CR) begin
            case (estado)
                ESPERA_FACE: begin
                    if (eh_face(dados_ascii)) begin
                        pendente_prox = face_de(dados_ascii);
                        estado_prox   = ESPERA_MOD;
                    end else if (dados_ascii == ASC_LF || dados_ascii == ASC_PV) begin
                        terminador = 1'b1;
                    end else begin
                        erro_novo = 1'b1;
                    end
                end
                ESPERA_MOD: begin
                    if (dados_ascii == ASC_APOS) begin
                        commit      = 1'b1;
                        commit_mod  = MOD_ANTI_HORARIO;
                        estado_prox = ESPERA_FACE;
                    end else if (dados_ascii == ASC_DOIS) begin
                        commit      = 1'b1;
                        commit_mod  = MOD_DUPLO;
                        estado_prox = ESPERA_FACE;
                    end else if (eh_face(dados_ascii)) begin
                        commit        = 1'b1;
                        pendente_prox = face_de(dados_ascii);
                    end else if (dados_ascii == ASC_LF || dados_ascii == ASC_PV) begin
                        commit      = 1'b1;
                        terminador  = 1'b1;
                        estado_prox = ESPERA_FACE;
                    end else begin
                        erro_novo     = 1'b1;
                        pendente_prox = FACE_U;
                        estado_prox   = ESPERA_FACE;
                    end
                end
                default: estado_prox = ESPERA_FACE;
            endcase
        end
    end

    // Parser state, pending face, terminator pulse and sticky flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado           <= ESPERA_FACE;
            pendente         <= FACE_U;
            sequencia_pronta <= 1'b0;
            erro_char        <= 1'b0;
            estouro          <= 1'b0;
        end else if (limpa) begin
            estado           <= ESPERA_FACE;
            pendente         <= FACE_U;
            sequencia_pronta <= 1'b0;
            erro_char        <= 1'b0;
            estouro          <= 1'b0;
        end else begin
            estado           <= estado_prox;
            pendente         <= pendente_prox;
            sequencia_pronta <= terminador;
            if (erro_novo) erro_char <= 1'b1;
            if (commit && cheia && !movimento_aceito) estouro <= 1'b1;
        end
    end

    fifo_sincrona #(
        .WIDTH  (5),
        .DEPTH  (DEPTH),
        .COUNT_W(CONT_W)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .flush(limpa),
        .push (commit),
        .din  (commit_dado),
        .pop  (movimento_aceito),
        .dout (movimento),
        .count(contagem)
    );

endmodule
